// File: rtl/imm_encoder_pkg.sv
// rtl/imm_encoder_pkg.sv - format select constants shared with the core immediate generator
package riscv_imm_pkg;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   // True when imm[31:lsb] are all equal, i.e. the value survives sign extension from bit lsb.
   function automatic logic sext_fits(input logic [31:0] imm, input int unsigned lsb);
      logic [31:0] t;
      t = $unsigned($signed(imm) >>> lsb);
      return (t == 32'h0) || (t == 32'hFFFF_FFFF);
   endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// rtl/imm_encoder_if.sv - input/output beat handshake bundle for imm_encoder
interface imm_encoder_if #(
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_sel;
   logic [31:0]      in_base;
   logic [31:0]      in_imm;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_instr;
   logic             out_err;
   logic [CNT_W-1:0] err_count;

   modport slave (
      input  in_valid, in_sel, in_base, in_imm, out_ready,
      output in_ready, out_valid, out_instr, out_err, err_count
   );

   modport master (
      output in_valid, in_sel, in_base, in_imm, out_ready,
      input  in_ready, out_valid, out_instr, out_err, err_count
   );
endinterface

// File: rtl/imm_encoder_pack.sv
// rtl/imm_encoder_pack.sv - combinational immediate packer with representability check
module imm_pack
   import riscv_imm_pkg::*;
(
   input  logic [2:0]  sel,
   input  logic [31:0] base,
   input  logic [31:0] imm,
   output logic [31:0] instr,
   output logic        err
);

   always_comb begin
      instr = base;
      err   = 1'b0;
      case (sel)
         IMM_I: begin
            instr = {imm[11:0], base[19:0]};
            err   = !sext_fits(imm, 11);
         end
         IMM_S: begin
            instr = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
            err   = !sext_fits(imm, 11);
         end
         IMM_B: begin
            instr = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
            err   = !sext_fits(imm, 12) || imm[0];
         end
         IMM_U: begin
            instr = {imm[31:12], base[11:0]};
            err   = (imm[11:0] != 12'h000);
         end
         IMM_J: begin
            instr = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
            err   = !sext_fits(imm, 20) || imm[0];
         end
         default: begin
            // Unknown format: leave the word untouched and flag it.
            instr = base;
            err   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - two-stage valid/ready immediate encoder with saturating error counter
module imm_encoder
   import riscv_imm_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic         clk,
   input  logic         reset,
   imm_encoder_if.slave bus
);

   logic             s1_valid;
   logic [2:0]       s1_sel;
   logic [31:0]      s1_base;
   logic [31:0]      s1_imm;
   logic             s2_valid;
   logic [31:0]      s2_instr;
   logic             s2_err;
   logic [CNT_W-1:0] err_count;
   logic [31:0]      pk_instr;
   logic             pk_err;
   logic             s2_adv;
   logic             s1_adv;

   imm_pack u_pack (
      .sel   (s1_sel),
      .base  (s1_base),
      .imm   (s1_imm),
      .instr (pk_instr),
      .err   (pk_err)
   );

   assign s2_adv = !s2_valid || bus.out_ready;
   assign s1_adv = !s1_valid || s2_adv;

   assign bus.in_ready  = !reset && s1_adv;
   assign bus.out_valid = s2_valid;
   assign bus.out_instr = s2_instr;
   assign bus.out_err   = s2_err;
   assign bus.err_count = err_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_sel    <= 3'b000;
         s1_base   <= 32'h0;
         s1_imm    <= 32'h0;
         s2_valid  <= 1'b0;
         s2_instr  <= 32'h0;
         s2_err    <= 1'b0;
         err_count <= '0;
      end else begin
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_instr <= pk_instr;
               s2_err   <= pk_err;
            end
         end
         if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
               s1_sel  <= bus.in_sel;
               s1_base <= bus.in_base;
               s1_imm  <= bus.in_imm;
            end
         end
         // Counts errored beats actually taken downstream; sticks at all-ones.
         if (s2_valid && bus.out_ready && s2_err && (err_count != {CNT_W{1'b1}}))
            err_count <= err_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - scoreboard bench for imm_encoder
module tb_imm_encoder;

   typedef struct {
      logic [31:0] instr;
      logic        err;
      logic [2:0]  sel;
      logic [31:0] imm;
   } exp_t;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;
   int   exp_cnt;
   bit   rnd_run;
   exp_t sb[$];

   imm_encoder_if #(.CNT_W(8)) bus ();

   imm_encoder #(.CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_pack(input logic [2:0] sel, input logic [31:0] base,
                                              input logic [31:0] imm, output logic err);
      logic [31:0] r;
      r   = base;
      err = 1'b0;
      if (sel == 3'd0) begin
         r[31:20] = imm[11:0];
         err = !(imm[31:11] == 21'h0 || imm[31:11] == 21'h1FFFFF);
      end else if (sel == 3'd1) begin
         r[31:25] = imm[11:5];
         r[11:7]  = imm[4:0];
         err = !(imm[31:11] == 21'h0 || imm[31:11] == 21'h1FFFFF);
      end else if (sel == 3'd2) begin
         r[31]    = imm[12];
         r[30:25] = imm[10:5];
         r[11:8]  = imm[4:1];
         r[7]     = imm[11];
         err = !(imm[31:12] == 20'h0 || imm[31:12] == 20'hFFFFF) || imm[0];
      end else if (sel == 3'd3) begin
         r[31:12] = imm[31:12];
         err = (imm[11:0] != 12'h0);
      end else if (sel == 3'd4) begin
         r[31]    = imm[20];
         r[30:21] = imm[10:1];
         r[20]    = imm[11];
         r[19:12] = imm[19:12];
         err = !(imm[31:20] == 12'h0 || imm[31:20] == 12'hFFF) || imm[0];
      end else begin
         err = 1'b1;
      end
      return r;
   endfunction

   // Core-side immediate generator used for the round-trip check.
   function automatic logic [31:0] decode(input logic [2:0] sel, input logic [31:0] i);
      case (sel)
         3'd0:    return {{20{i[31]}}, i[31:20]};
         3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
         3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         3'd3:    return {i[31:12], 12'h000};
         default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      endcase
   endfunction

   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         check("err_count", {24'h0, bus.err_count}, exp_cnt);
         if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_instr", bus.out_instr, e.instr);
            check("out_err", {31'h0, bus.out_err}, {31'h0, e.err});
            if (!e.err && e.sel <= 3'd4)
               check("roundtrip", decode(e.sel, bus.out_instr), e.imm);
            if (bus.out_err && exp_cnt < 255) exp_cnt++;
         end
      end
   end

   task automatic send(input logic [2:0] sel, input logic [31:0] base, input logic [31:0] imm);
      int   n;
      exp_t e;
      logic err;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_sel   = sel;
      bus.in_base  = base;
      bus.in_imm   = imm;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.in_ready && n < 200);
      if (!bus.in_ready) begin
         check("in_ready_timeout", 32'd0, 32'd1);
      end else begin
         e.instr = model_pack(sel, base, imm, err);
         e.err   = err;
         e.sel   = sel;
         e.imm   = imm;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic directed(input string tag, input logic [2:0] sel, input logic [31:0] base,
                           input logic [31:0] imm, input logic [31:0] exp_instr,
                           input logic exp_err);
      send(sel, base, imm);
      @(negedge clk);
      check({tag, "_lat1"}, {31'h0, bus.out_valid}, 32'd0);
      @(negedge clk);
      check({tag, "_lat2"}, {31'h0, bus.out_valid}, 32'd1);
      check({tag, "_instr"}, bus.out_instr, exp_instr);
      check({tag, "_err"}, {31'h0, bus.out_err}, {31'h0, exp_err});
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      exp_cnt = 0;
      rnd_run = 1'b0;
      reset = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_sel    = 3'b000;
      bus.in_base   = 32'h0;
      bus.in_imm    = 32'h0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
      check("rst_out_instr", bus.out_instr, 32'h0);
      check("rst_out_err", {31'h0, bus.out_err}, 32'd0);
      check("rst_err_count", {24'h0, bus.err_count}, 32'd0);
      check("rst_in_ready", {31'h0, bus.in_ready}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;

      directed("I",   3'b000, 32'h0003_0293, 32'hFFFF_F800, 32'h8003_0293, 1'b0);
      directed("B",   3'b010, 32'h0020_9063, 32'hFFFF_FFFC, 32'hFE20_9EE3, 1'b0);
      directed("Be",  3'b010, 32'h0020_9063, 32'h0000_0801, model_pack(3'b010, 32'h0020_9063, 32'h0000_0801, bus.in_valid), 1'b1);
      check("B_err_count", {24'h0, bus.err_count}, 32'd1);
      directed("U",   3'b011, 32'h0000_0537, 32'h1234_5000, 32'h1234_5537, 1'b0);
      directed("Ue",  3'b011, 32'h0000_0537, 32'h1234_5001, 32'h1234_5537, 1'b1);
      directed("inv", 3'b101, 32'h0000_0537, 32'h1234_5000, 32'h0000_0537, 1'b1);
      check("U_err_count", {24'h0, bus.err_count}, 32'd3);

      // Backpressure: out_ready low for 3 cycles while 4 beats arrive back to back.
      bus.out_ready = 1'b0;
      fork
         begin
            send(3'b000, 32'h0000_0013, 32'h0000_07FF);
            send(3'b001, 32'h0000_2023, 32'hFFFF_F800);
            check("bp_in_ready_full", {31'h0, bus.in_ready}, 32'd0);
            send(3'b010, 32'h0000_0063, 32'h0000_0FFE);
            send(3'b100, 32'h0000_006F, 32'hFFF0_0000);
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               check("bp_no_gap", {31'h0, bus.out_valid}, 32'd1);
            end
         end
      join
      drain();

      // Reset with both stages full.
      bus.out_ready = 1'b0;
      send(3'b000, 32'h0000_0013, 32'h0000_0001);
      send(3'b000, 32'h0000_0013, 32'h0000_0002);
      check("full_in_ready", {31'h0, bus.in_ready}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_in_ready", {31'h0, bus.in_ready}, 32'd0);
      @(posedge clk);
      #1;
      sb.delete();
      exp_cnt = 0;
      check("mid_rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
      check("mid_rst_err_count", {24'h0, bus.err_count}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_in_ready_after", {31'h0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;

      // Saturation.
      for (int k = 0; k < 300; k++)
         send(3'd5 + 3'(k % 3), $urandom, $urandom);
      drain();
      check("sat_err_count", {24'h0, bus.err_count}, 32'd255);

      // Random mix with random backpressure.
      rnd_run = 1'b1;
      fork
         begin
            for (int k = 0; k < 300; k++) begin
               logic [2:0]  s;
               logic [31:0] im;
               s  = 3'($urandom_range(0, 4));
               im = $urandom;
               if ($urandom % 4 != 0) begin
                  case (s)
                     3'd0, 3'd1: im = {{20{im[11]}}, im[11:0]};
                     3'd2:       im = {{19{im[12]}}, im[12:1], 1'b0};
                     3'd3:       im = {im[31:12], 12'h000};
                     default:    im = {{11{im[20]}}, im[20:1], 1'b0};
                  endcase
               end
               send(s, $urandom, im);
            end
            rnd_run = 1'b0;
         end
         begin
            while (rnd_run) begin
               @(posedge clk);
               #1;
               bus.out_ready = ($urandom % 4) != 0;
            end
            bus.out_ready = 1'b1;
         end
      join
      drain();
      check("final_err_count", {24'h0, bus.err_count}, 32'd255);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
